// File: rtl/note_player.sv
// Note player: takes a note word from the song sequencer, holds its note index for the
// encoded number of beats with a built-in beat prescaler, then requests the next word.
module note_player #(
  parameter int unsigned BEAT_CYCLES = 1000000,
  parameter int unsigned CNT_W       = 20,
  parameter bit          ARTIC       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        new_note,
  input  logic [15:0] note_data,
  output logic        note_done,
  output logic [5:0]  note,
  output logic        note_active,
  output logic        beat,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(BEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [5:0]       beats_left_q, beats_left_d;
  logic [5:0]       dur_q, dur_d;
  logic [5:0]       note_q, note_d;
  logic             overrun_q, overrun_d;

  logic             beat_tick;
  logic             mute;
  logic             unused_hi;

  // The top nibble of the note word carries nothing for this block.
  assign unused_hi = ^note_data[15:12];

  assign beat_tick = (state_q == PLAYING) && play && (presc_q == LAST_TICK);

  // Articulation gap: silence the last beat of multi-beat notes so repeats are audible.
  generate
    if (ARTIC) begin : g_artic
      assign mute = (dur_q > 6'd1) && (beats_left_q == 6'd1);
    end else begin : g_no_artic
      assign mute = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    beats_left_d = beats_left_q;
    dur_d        = dur_q;
    note_d       = note_q;
    overrun_d    = overrun_q;

    if (new_note) begin
      // A word is accepted in every state; arriving mid-note it preempts and flags overrun.
      state_d      = PLAYING;
      presc_d      = '0;
      note_d       = note_data[11:6];
      beats_left_d = note_data[5:0];
      dur_d        = note_data[5:0];
      if (state_q == PLAYING) begin
        overrun_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        PLAYING: begin
          if (beats_left_q == 6'd0) begin
            state_d = DONE;
          end else if (beat_tick) begin
            presc_d      = '0;
            beats_left_d = beats_left_q - 6'd1;
            if (beats_left_q == 6'd1) begin
              state_d = DONE;
            end
          end else if (play) begin
            presc_d = presc_q + 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      beats_left_q <= 6'd0;
      dur_q        <= 6'd0;
      note_q       <= 6'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      beats_left_q <= beats_left_d;
      dur_q        <= dur_d;
      note_q       <= note_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    note_active = (state_q == PLAYING);
    note_done   = (state_q == DONE);
    note        = (note_active && !mute) ? note_q : 6'd0;
    beat        = beat_tick;
    overrun     = overrun_q;
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed scenarios with cycle-exact expectations on two
// instances (articulation on/off), plus a randomized run against a beat-count model.
module tb_note_player;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        reset, play, new_note;
  logic [15:0] note_data;
  logic        d1, a1, b1, o1, d0, a0, b0, o0;
  logic [5:0]  n1, n0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [19:0] obs, e_model, exp_v;

  // Reference model: counts play-high cycles since the note started.
  bit m_playing, m_done, m_ovr;
  int m_note, m_dur, m_a;

  always #5 clk = ~clk;

  note_player #(.BEAT_CYCLES(BC), .CNT_W(3), .ARTIC(1'b1)) u_art (
    .clk(clk), .reset(reset), .play(play), .new_note(new_note), .note_data(note_data),
    .note_done(d1), .note(n1), .note_active(a1), .beat(b1), .overrun(o1)
  );

  note_player #(.BEAT_CYCLES(BC), .CNT_W(3), .ARTIC(1'b0)) u_noart (
    .clk(clk), .reset(reset), .play(play), .new_note(new_note), .note_data(note_data),
    .note_done(d0), .note(n0), .note_active(a0), .beat(b0), .overrun(o0)
  );

  function automatic logic [19:0] pk(input logic act, input logic [5:0] nt1, input logic [5:0] nt0,
                                     input logic bt, input logic dn, input logic ov);
    return {act, nt1, bt, dn, ov, act, nt0, bt, dn, ov};
  endfunction

  // One clock cycle: sample outputs at negedge, then advance the model at posedge.
  task automatic adv();
    int rem;
    bit mute;
    @(negedge clk);
    obs  = {a1, n1, b1, d1, o1, a0, n0, b0, d0, o0};
    rem  = m_dur - m_a / BC;
    mute = (m_dur > 1) && (rem == 1);
    e_model = pk(m_playing, (m_playing && !mute) ? 6'(m_note) : 6'd0,
                 m_playing ? 6'(m_note) : 6'd0,
                 m_playing && play && (m_a % BC == BC - 1), m_done, m_ovr);
    @(posedge clk);
    if (reset) begin
      m_playing = 0; m_done = 0; m_ovr = 0; m_note = 0; m_dur = 0; m_a = 0;
    end else if (new_note) begin
      if (m_playing) m_ovr = 1;
      m_playing = 1; m_done = 0; m_a = 0;
      m_note = int'(note_data[11:6]);
      m_dur  = int'(note_data[5:0]);
    end else if (m_playing) begin
      m_done = 0;
      if (m_dur == 0) begin
        m_playing = 0; m_done = 1;
      end else if (play) begin
        m_a++;
        if (m_a == m_dur * BC) begin
          m_playing = 0; m_done = 1;
        end
      end
    end else begin
      m_done = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; new_note = 1'b0; play = 1'b0; note_data = 16'h0;
    adv(); adv();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    adv();
    n_checks++;
    if (obs !== 20'h0) $display("FAIL reset_state: got %h expected %h", obs, 20'h0);
    else n_pass++;
    play = 1'b1; new_note = 1'b1; note_data = 16'h0282;
    adv();
    new_note = 1'b0;
    adv();
    reset = 1'b1; new_note = 1'b1; note_data = 16'h0FC5;
    adv();
    reset = 1'b0; new_note = 1'b0;
    for (int c = 0; c < 3; c++) begin
      adv();
      n_checks++;
      if (obs !== 20'h0) $display("FAIL reset_wins c%0d: got %h expected %h", c, obs, 20'h0);
      else n_pass++;
    end
  endtask

  task automatic test_artic();
    do_reset();
    play = 1'b1; new_note = 1'b1; note_data = 16'h0282;
    adv();
    new_note = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      note_data = 16'($urandom);
      adv();
      exp_v = pk(c <= 8, (c <= 4) ? 6'd10 : 6'd0, (c <= 8) ? 6'd10 : 6'd0,
                 (c == 4) || (c == 8), c == 9, 1'b0);
      n_checks++;
      if (obs !== exp_v) $display("FAIL artic c%0d: got %h expected %h", c, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    do_reset();
    play = 1'b1; new_note = 1'b1; note_data = 16'h0281;
    adv();
    new_note = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      play = !((c >= 2) && (c <= 5));
      adv();
      exp_v = pk(c <= 8, (c <= 8) ? 6'd10 : 6'd0, (c <= 8) ? 6'd10 : 6'd0,
                 c == 8, c == 9, 1'b0);
      n_checks++;
      if (obs !== exp_v) $display("FAIL pause c%0d: got %h expected %h", c, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_zero_dur();
    do_reset();
    play = 1'b1; new_note = 1'b1; note_data = 16'h0280;
    adv();
    new_note = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      adv();
      exp_v = pk(c == 1, (c == 1) ? 6'd10 : 6'd0, (c == 1) ? 6'd10 : 6'd0,
                 1'b0, c == 2, 1'b0);
      n_checks++;
      if (obs !== exp_v) $display("FAIL zero_dur c%0d: got %h expected %h", c, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    play = 1'b1; new_note = 1'b1; note_data = 16'h0041;
    adv();
    for (int c = 1; c <= 11; c++) begin
      new_note  = (c == 5);
      note_data = (c == 5) ? 16'h00C1 : 16'h0000;
      adv();
      exp_v = pk(((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9)),
                 (c <= 4) ? 6'd1 : ((c >= 6) && (c <= 9)) ? 6'd3 : 6'd0,
                 (c <= 4) ? 6'd1 : ((c >= 6) && (c <= 9)) ? 6'd3 : 6'd0,
                 (c == 4) || (c == 9), (c == 5) || (c == 10), 1'b0);
      n_checks++;
      if (obs !== exp_v) $display("FAIL back_to_back c%0d: got %h expected %h", c, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_preempt();
    logic [5:0] nt;
    do_reset();
    play = 1'b1; new_note = 1'b1; note_data = 16'h0283;
    adv();
    for (int c = 1; c <= 20; c++) begin
      new_note  = (c == 3) || (c == 10);
      note_data = (c == 3) ? 16'h0141 : 16'h0282;
      reset     = (c == 16);
      adv();
      if (c <= 9) begin
        nt = (c <= 3) ? 6'd10 : (c <= 7) ? 6'd5 : 6'd0;
        exp_v = pk(c <= 7, nt, nt, c == 7, c == 8, c >= 4);
      end else if (c <= 16) begin
        exp_v = pk(c >= 11, ((c >= 11) && (c <= 14)) ? 6'd10 : 6'd0,
                   (c >= 11) ? 6'd10 : 6'd0, c == 14, 1'b0, 1'b1);
      end else begin
        exp_v = 20'h0;
      end
      n_checks++;
      if (obs !== exp_v) $display("FAIL preempt c%0d: got %h expected %h", c, obs, exp_v);
      else n_pass++;
    end
    reset = 1'b0; new_note = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 399) == 0);
      new_note = m_playing ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 2) == 0);
      play     = ($urandom_range(0, 4) != 0);
      note_data = {4'($urandom), 6'($urandom), 6'($urandom_range(0, 5))};
      adv();
      n_checks++;
      if (obs !== e_model) $display("FAIL random i%0d: got %h expected %h", i, obs, e_model);
      else n_pass++;
    end
    reset = 1'b0; new_note = 1'b0;
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; new_note = 1'b0; note_data = 16'h0;
    m_playing = 0; m_done = 0; m_ovr = 0; m_note = 0; m_dur = 0; m_a = 0;
    test_reset();
    test_artic();
    test_pause();
    test_zero_dur();
    test_back_to_back();
    test_preempt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
